// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its one-hot encoder.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width for n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc.sv
// One-hot to binary encoder: each index bit ORs the one-hot lines whose position has that bit set.
module enc
    import arb_pkg::*;
#(
    parameter int W     = 4,
    parameter int IDX_W = idx_w(W)
) (
    input  logic [W-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_bit
            logic [W-1:0] sel;
            for (gj = 0; gj < W; gj++) begin : g_sel
                assign sel[gj] = onehot[gj] & (((gj >> gi) & 1) == 1);
            end
            assign idx[gi] = |sel;
        end
    endgenerate

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter with multi-beat bursts; grant held from first beat until ack+last,
// then handed to the next requester in cyclic order without an idle bubble.
module arb_rr
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N-1:0]     req_i,
    input  logic             last_i,
    input  logic             ack_i,
    output logic             gnt_vld_o,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    state_t           state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [N-1:0]     gnt_reg;
    logic [IDX_W-1:0] gnt_idx_reg;
    logic             gnt_vld_reg;

    logic             release_c;
    logic [IDX_W-1:0] rel_ptr;
    logic [IDX_W-1:0] arb_ptr;
    logic [N-1:0]     arb_req;
    logic [N-1:0]     rot_req;
    logic [N-1:0]     rot_pick;
    logic [N-1:0]     win_oh;
    logic [IDX_W-1:0] win_idx;
    logic             found;

    // (p + o) mod N for p < N, o < N; keeps non-power-of-2 N inside valid codes.
    function automatic int wrap_add(input logic [IDX_W-1:0] p, input int o);
        int s;
        s = int'(p) + o;
        return (s >= N) ? s - N : s;
    endfunction

    // On release the updated pointer and the mask excluding the current winner arbitrate directly.
    always_comb begin
        release_c = (state_reg == BUSY) && ack_i && last_i;
        rel_ptr   = (gnt_idx_reg == IDX_W'(N - 1)) ? '0 : gnt_idx_reg + 1'b1;
        arb_ptr   = (state_reg == BUSY) ? rel_ptr : ptr_reg;
        arb_req   = (state_reg == BUSY) ? (req_i & ~gnt_reg) : req_i;
    end

    always_comb begin
        rot_req  = '0;
        rot_pick = '0;
        win_oh   = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            rot_req[i] = arb_req[wrap_add(arb_ptr, i)];
        end
        for (int i = 0; i < N; i++) begin
            if (rot_req[i] && !found) begin
                rot_pick[i] = 1'b1;
                found       = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rot_pick[i]) begin
                win_oh[wrap_add(arb_ptr, i)] = 1'b1;
            end
        end
    end

    enc #(
        .W     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .onehot (win_oh),
        .idx    (win_idx)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gnt_reg     <= '0;
            gnt_idx_reg <= '0;
            gnt_vld_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        state_reg   <= BUSY;
                        gnt_reg     <= win_oh;
                        gnt_idx_reg <= win_idx;
                        gnt_vld_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    if (release_c) begin
                        ptr_reg <= rel_ptr;
                        if (found) begin
                            gnt_reg     <= win_oh;
                            gnt_idx_reg <= win_idx;
                        end else begin
                            state_reg   <= IDLE;
                            gnt_reg     <= '0;
                            gnt_idx_reg <= '0;
                            gnt_vld_reg <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt_vld_o = gnt_vld_reg;
    assign gnt_o     = gnt_reg;
    assign gnt_idx_o = gnt_idx_reg;

    // The granted requester must keep requesting until its final beat is acked.
    a_winner_holds_req: assert property (@(posedge clk) disable iff (arst)
        gnt_vld_reg |-> |(req_i & gnt_reg));
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (arst)
        $onehot0(gnt_reg));
    a_vld_matches: assert property (@(posedge clk) disable iff (arst)
        gnt_vld_reg == (gnt_reg != '0));
    a_idx_idle_zero: assert property (@(posedge clk) disable iff (arst)
        !gnt_vld_reg |-> (gnt_idx_reg == '0));
    a_idx_encodes: assert property (@(posedge clk) disable iff (arst)
        gnt_vld_reg |-> gnt_reg[gnt_idx_reg]);

endmodule

// File: tb/tb_arb_rr.sv
// Self-checking bench for arb_rr (N=4): per-cycle vector table through a scoreboard queue,
// plus a hand-written mid-burst reset sequence.
module tb_arb_rr;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             arst;
    logic [N-1:0]     req_i;
    logic             last_i;
    logic             ack_i;
    logic             gnt_vld_o;
    logic [N-1:0]     gnt_o;
    logic [IDX_W-1:0] gnt_idx_o;

    arb_rr #(.N(N)) dut (
        .clk       (clk),
        .arst      (arst),
        .req_i     (req_i),
        .last_i    (last_i),
        .ack_i     (ack_i),
        .gnt_vld_o (gnt_vld_o),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             vld;
        logic [N-1:0]     gnt;
        logic [IDX_W-1:0] idx;
    } exp_t;

    typedef struct packed {
        logic [N-1:0] req;
        logic         ack;
        logic         last;
        exp_t         exp;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    task automatic check_out(input string name, input exp_t e);
        checks++;
        if (gnt_vld_o !== e.vld || gnt_o !== e.gnt || gnt_idx_o !== e.idx) begin
            errors++;
            $display("FAIL %s: got vld=%b gnt=%b idx=%0d, expected vld=%b gnt=%b idx=%0d",
                     name, gnt_vld_o, gnt_o, gnt_idx_o, e.vld, e.gnt, e.idx);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic step(input string name, input logic [N-1:0] r, input logic a,
                        input logic l, input exp_t e);
        exp_t got_e;
        req_i  = r;
        ack_i  = a;
        last_i = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        txn++;
        $display("txn %0d %s req=%b ack=%b last=%b -> vld=%b gnt=%b idx=%0d",
                 txn, name, r, a, l, gnt_vld_o, gnt_o, gnt_idx_o);
        check_out(name, got_e);
    endtask

    task automatic check_ptr(input string name, input logic [IDX_W-1:0] exp_ptr);
        checks++;
        if (dut.ptr_reg !== exp_ptr) begin
            errors++;
            $display("FAIL %s: got ptr=%0d, expected ptr=%0d", name, dut.ptr_reg, exp_ptr);
        end
    endtask

    initial begin
        //           req      ack  last  vld  gnt      idx
        vecs[0]  = '{4'b1010, 1'b0, 1'b0, '{1'b1, 4'b0010, 2'd1}}; // 1-cycle latency, winner 1
        vecs[1]  = '{4'b1010, 1'b1, 1'b1, '{1'b1, 4'b1000, 2'd3}}; // no-gap handoff to 3
        vecs[2]  = '{4'b1000, 1'b1, 1'b1, '{1'b0, 4'b0000, 2'd0}}; // release, nobody else -> idle
        vecs[3]  = '{4'b0000, 1'b1, 1'b1, '{1'b0, 4'b0000, 2'd0}}; // ack+last while idle ignored
        vecs[4]  = '{4'b1111, 1'b0, 1'b0, '{1'b1, 4'b0001, 2'd0}}; // ptr 0 after wrap from 3
        vecs[5]  = '{4'b1111, 1'b1, 1'b1, '{1'b1, 4'b0010, 2'd1}};
        vecs[6]  = '{4'b1111, 1'b1, 1'b1, '{1'b1, 4'b0100, 2'd2}};
        vecs[7]  = '{4'b1111, 1'b1, 1'b1, '{1'b1, 4'b1000, 2'd3}};
        vecs[8]  = '{4'b1111, 1'b1, 1'b1, '{1'b1, 4'b0001, 2'd0}}; // wrap 3 -> 0
        vecs[9]  = '{4'b1111, 1'b1, 1'b1, '{1'b1, 4'b0010, 2'd1}};
        vecs[10] = '{4'b0111, 1'b1, 1'b1, '{1'b1, 4'b0100, 2'd2}}; // winner 2, req 0 pending
        vecs[11] = '{4'b0101, 1'b1, 1'b0, '{1'b1, 4'b0100, 2'd2}}; // beat 1
        vecs[12] = '{4'b0101, 1'b1, 1'b0, '{1'b1, 4'b0100, 2'd2}}; // beat 2
        vecs[13] = '{4'b0101, 1'b0, 1'b1, '{1'b1, 4'b0100, 2'd2}}; // last without ack held
        vecs[14] = '{4'b0101, 1'b1, 1'b1, '{1'b1, 4'b0001, 2'd0}}; // beat 3 release -> 0
        vecs[15] = '{4'b0001, 1'b1, 1'b1, '{1'b0, 4'b0000, 2'd0}}; // ptr -> 1, idle
        vecs[16] = '{4'b0010, 1'b0, 1'b0, '{1'b1, 4'b0010, 2'd1}}; // lone requester 1
        vecs[17] = '{4'b0010, 1'b1, 1'b1, '{1'b0, 4'b0000, 2'd0}}; // one-cycle gap
        vecs[18] = '{4'b0010, 1'b0, 1'b0, '{1'b1, 4'b0010, 2'd1}}; // re-grant from idle
        vecs[19] = '{4'b0010, 1'b1, 1'b1, '{1'b0, 4'b0000, 2'd0}}; // ptr -> 2
        vecs[20] = '{4'b1000, 1'b0, 1'b0, '{1'b1, 4'b1000, 2'd3}}; // grant 3 for reset test

        arst   = 1'b1;
        req_i  = '0;
        ack_i  = 1'b0;
        last_i = 1'b0;
        #1;
        check_out("reset_state", '{1'b0, 4'b0000, 2'd0});
        check_ptr("reset_ptr", 2'd0);
        #12;
        arst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i == 20) check_ptr("ptr_after_lone_req1", 2'd2);
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].ack, vecs[i].last, vecs[i].exp);
        end

        // Mid-burst reset: grant 3 held, then reset asynchronously between edges.
        step("burst3_beat", 4'b1000, 1'b1, 1'b0, '{1'b1, 4'b1000, 2'd3});
        #2;
        arst = 1'b1;
        #1;
        check_out("async_reset_midburst", '{1'b0, 4'b0000, 2'd0});
        check_ptr("ptr_after_reset", 2'd0);
        @(negedge clk);
        arst = 1'b0;
        step("post_reset_req1001", 4'b1001, 1'b0, 1'b0, '{1'b1, 4'b0001, 2'd0});
        step("post_reset_hold", 4'b1001, 1'b1, 1'b0, '{1'b1, 4'b0001, 2'd0});
        step("post_reset_handoff", 4'b1001, 1'b1, 1'b1, '{1'b1, 4'b1000, 2'd3});
        step("post_reset_release", 4'b1000, 1'b1, 1'b1, '{1'b0, 4'b0000, 2'd0});

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
